// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM state encoding for the add_ALU command path.
package alu_pkg;

    localparam int ALU_DATA_W = 3;
    localparam int ALU_RES_W  = 6;
    localparam int ALU_OP_W   = 2;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding command issuer for add_ALU: registers operands, holds alu_en for
// ALU_LAT cycles, then presents the captured result over a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int RES_W   = ALU_RES_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_dout,
    input  logic              alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int LAT_W = $clog2(ALU_LAT + 1);

    alu_state_e        state_reg,     state_next;
    logic [LAT_W-1:0]  lat_cnt_reg,   lat_cnt_next;
    logic [OP_W-1:0]   op_reg,        op_next;
    logic [DATA_W-1:0] a_reg,         a_next;
    logic [DATA_W-1:0] b_reg,         b_next;
    logic [RES_W-1:0]  rsp_data_reg,  rsp_data_next;
    logic              rsp_carry_reg, rsp_carry_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [CNT_W-1:0]  done_cnt_reg,  done_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            done_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            lat_cnt_reg   <= lat_cnt_next;
            op_reg        <= op_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_carry_reg <= rsp_carry_next;
            rsp_valid_reg <= rsp_valid_next;
            done_cnt_reg  <= done_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lat_cnt_next   = lat_cnt_reg;
        op_next        = op_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_carry_next = rsp_carry_reg;
        rsp_valid_next = rsp_valid_reg;
        done_cnt_next  = done_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next      = cmd_op;
                    a_next       = cmd_a;
                    b_next       = cmd_b;
                    lat_cnt_next = LAT_W'(ALU_LAT);
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                // The ALU output is sampled on the last enabled edge, when it is guaranteed valid.
                if (lat_cnt_reg == LAT_W'(1)) begin
                    rsp_data_next  = alu_dout;
                    rsp_carry_next = alu_c;
                    rsp_valid_next = 1'b1;
                    lat_cnt_next   = '0;
                    state_next     = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    done_cnt_next  = done_cnt_reg + CNT_W'(1);
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign alu_en    = (state_reg == EXEC);
    assign busy      = (state_reg != IDLE);
    assign alu_op    = op_reg;
    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;
    assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a behavioural stand-in for add_ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int ALU_LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_a, cmd_b;
    logic       alu_en;
    logic [1:0] alu_op;
    logic [2:0] alu_a, alu_b;
    logic [5:0] alu_dout;
    logic       alu_c;
    logic       rsp_valid, rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_carry;
    logic       busy;
    logic [7:0] done_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // add_ALU stand-in: combinational add, carry is the bit above the operand width.
    logic [3:0] alu_sum;
    assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_dout = (alu_op == ALU_OP_ADD) ? {2'b00, alu_sum} : 6'd0;
    assign alu_c    = (alu_op == ALU_OP_ADD) & alu_sum[3];

    alu_issue_ctrl #(
        .DATA_W(3), .RES_W(6), .OP_W(2), .ALU_LAT(ALU_LAT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_dout(alu_dout), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .busy(busy), .done_cnt(done_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a command and return at the negedge right after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 40 && !cmd_ready; i++) step();
        chk("issue_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        $display("[TB] issue op=%0d a=%0d b=%0d", op, a, b);
    endtask

    // Edges counted from the accepting edge until rsp_valid is seen.
    task automatic run_to_rsp(output int edges, output int en_cyc);
        edges  = 1;
        en_cyc = 0;
        while (!rsp_valid && edges < 40) begin
            if (alu_en) en_cyc++;
            step();
            edges++;
        end
        $display("[TB] response data=%0d carry=%0d after %0d edges", rsp_data, rsp_carry, edges);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int          e, en, ci, ri, last_cyc;
    logic        acc;
    int unsigned op_a[4] = '{1, 1, 3, 6};
    int unsigned op_b[4] = '{0, 1, 3, 6};
    int unsigned exp5[4] = '{1, 2, 6, 12};

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 3'd0;
        cmd_b     = 3'd0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single add 3+3
        rsp_ready = 1'b1;
        issue(ALU_OP_ADD, 3'd3, 3'd3);
        chk("t2_alu_en", alu_en, 1);
        chk("t2_alu_a", alu_a, 3);
        chk("t2_alu_b", alu_b, 3);
        run_to_rsp(e, en);
        chk("t2_latency", e, ALU_LAT + 1);
        chk("t2_data", rsp_data, 6);
        chk("t2_carry", rsp_carry, 0);
        step();
        chk("t2_rsp_clear", rsp_valid, 0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_busy", busy, 0);

        // Max operands 7+7
        issue(ALU_OP_ADD, 3'd7, 3'd7);
        run_to_rsp(e, en);
        chk("t3_en_cycles", en, ALU_LAT);
        chk("t3_data", rsp_data, 14);
        chk("t3_carry", rsp_carry, 1);
        chk("t3_en_in_resp", alu_en, 0);
        step();
        chk("t3_alu_a_held", alu_a, 7);
        chk("t3_done_cnt", done_cnt, 2);

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        issue(ALU_OP_ADD, 3'd5, 3'd4);
        run_to_rsp(e, en);
        cmd_valid = 1'b1;
        cmd_op    = ALU_OP_ADD;
        cmd_a     = 3'd2;
        cmd_b     = 3'd1;
        repeat (5) begin
            chk("t4_valid_hold", rsp_valid, 1);
            chk("t4_data_hold", rsp_data, 9);
            chk("t4_carry_hold", rsp_carry, 1);
            chk("t4_cmd_ready", cmd_ready, 0);
            step();
        end
        chk("t4_held_off", alu_a, 5);
        rsp_ready = 1'b1;
        step();
        chk("t4_rsp_clear", rsp_valid, 0);
        chk("t4_done_cnt1", done_cnt, 3);
        chk("t4_ready_again", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("t4_second_a", alu_a, 2);
        chk("t4_busy", busy, 1);
        run_to_rsp(e, en);
        chk("t4_second_data", rsp_data, 3);
        step();
        chk("t4_done_cnt2", done_cnt, 4);

        // Back-to-back with the upstream always offering the next command
        ci = 0;
        ri = 0;
        last_cyc = 0;
        cmd_valid = 1'b1;
        cmd_op    = ALU_OP_ADD;
        cmd_a     = 3'(op_a[0]);
        cmd_b     = 3'(op_b[0]);
        for (int cyc = 0; cyc < 60 && ri < 4; cyc++) begin
            if (rsp_valid) begin
                $display("[TB] b2b rsp %0d data=%0d cycle=%0d", ri, rsp_data, cyc);
                chk("t5_data", rsp_data, exp5[ri]);
                if (ri > 0) chk("t5_spacing", cyc - last_cyc, ALU_LAT + 2);
                last_cyc = cyc;
                ri++;
            end
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                ci++;
                if (ci < 4) begin
                    cmd_a = 3'(op_a[ci]);
                    cmd_b = 3'(op_b[ci]);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        chk("t5_rsp_count", ri, 4);
        chk("t5_done_cnt", done_cnt, 8);

        // Reset one cycle into EXEC aborts the command
        issue(ALU_OP_ADD, 3'd1, 3'd1);
        chk("t6_in_exec", alu_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_alu_en", alu_en, 0);
        chk("t6_done_cnt", done_cnt, 0);
        chk("t6_alu_a", alu_a, 0);
        @(negedge clk);
        repeat (3) begin
            chk("t6_no_rsp", rsp_valid, 0);
            step();
        end
        rst_n = 1'b1;
        step();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_ready", cmd_ready, 1);
        chk("t6_idle_rsp", rsp_valid, 0);
        issue(ALU_OP_ADD, 3'd2, 3'd2);
        run_to_rsp(e, en);
        chk("t6_post_data", rsp_data, 4);
        step();
        chk("t6_post_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
